muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit inside the execute stage.
- Its result becomes `dataE.rst` for M-extension instructions.
- The execute stage stalls the pipeline while `busy` is high. It releases the instruction to the memory stage once `done` is high and it raises `ack`.
- `flush` kills an in-flight operation when an exception or redirect invalidates the instruction.

Parameters:
- XLEN, 64, datapath width; word_t width.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- valid_in  in  1  start request; sampled only in IDLE, or in DONE together with ack
- op  in  muldiv_op_t (4)  operation: MUL, MULH, MULHU, MULHSU, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW
- srca  in  XLEN  operand a (rs1)
- srcb  in  XLEN  operand b (rs2)
- flush  in  1  abort the current operation
- ack  in  1  consumer takes the result
- busy  out  1  operation in progress (states MUL or DIV)
- done  out  1  result valid (state DONE)
- result  out  XLEN  final result; held stable while done is high

Behaviour:
- Reset (resetn low, asynchronous): state goes to IDLE.
  - busy=0, done=0, result=0.
  - Counter, accumulators and latched op are all cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE + valid_in:
  - Latch op and operands.
  - For W ops, latch the low 32 bits, sign- or zero-extended as the op requires.
  - Go to MUL or DIV. The counter loads 64, or 32 for W ops.
- Fast path, decided in the accept cycle, with no iteration:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - W ops test these cases on their 32-bit operands.
  - Go directly to DONE. Latency is 1 cycle: accept at edge N, done=1 after edge N+1.
- MUL:
  - Shift-add, one multiplier bit per cycle, into a 128-bit product register.
  - Signed variants operate on magnitudes; the sign is fixed up on the final cycle.
  - MULHSU treats only srca as signed.
  - When the counter reaches 1, go to DONE.
- DIV:
  - Restoring division, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Latency, accept edge to done high:
  - 64-bit ops: 65 cycles.
  - W ops: 33 cycles.
  - Fast path: 1 cycle.
- Result selection:
  - MUL: low XLEN bits.
  - MULH*: high XLEN bits.
  - DIV*: quotient.
  - REM*: remainder.
  - W ops: bit 31 sign-extended to 64 bits, including DIVUW and REMUW.
- DONE:
  - done=1 and result stable until ack.
  - ack without valid_in: go to IDLE.
  - ack with valid_in: accept the new op in the same cycle (back-to-back, no bubble).
  - No ack: hold; valid_in is ignored.
- flush:
  - In any state, flush goes to IDLE next cycle with busy=0 and done=0.
  - The result register is not required to be cleared.
  - flush has priority over valid_in and ack in the same cycle. A flush+valid_in in IDLE does not start.
- busy is never high in IDLE or DONE. busy and done are never high together.
- Operands change while busy: ignored, because they are latched at accept.

Decomposition:
- muldiv_op_t enum goes in package pipes, beside execute_data_t. The decoder's control struct carries a muldiv_op_t field.
- Iteration count constants MULDIV_ITER_D=64 and MULDIV_ITER_W=32 go in common.
- One natural sub-module: div_iter. It is the restoring divider step on unsigned magnitudes: partial remainder and quotient registers, one step per enable.
- muldiv_unit keeps the FSM, the sign handling, the fast path and the multiplier.

Test Plan:
- MUL srca=7, srcb=-3 -> after 65 cycles, done=1 and result=0xFFFF_FFFF_FFFF_FFEB. Hold 3 cycles without ack: result is stable and busy=0.
- MULHU srca=0xFFFF_FFFF_FFFF_FFFF, srcb=2 -> result=1. MULH with the same operands -> result=0xFFFF_FFFF_FFFF_FFFF.
- DIVW srca=0x0000_0000_8000_0000, srcb=0xFFFF_FFFF -> fast path: done after 1 cycle, result=0xFFFF_FFFF_8000_0000. REMW with the same operands -> result=0.
- DIV srca=-20, srcb=0 -> done after 1 cycle, result=0xFFFF_FFFF_FFFF_FFFF. REMU srca=20, srcb=0 -> result=20.
- REM srca=-7, srcb=2 -> result=-1 after 65 cycles. Then in the same cycle assert ack and start DIVUW srca=0xFFFF_FFFF, srcb=2 -> done after 33 cycles, result=0x0000_0000_7FFF_FFFF sign-extended to 0x0000_0000_7FFF_FFFF.
- Start DIV, assert flush at cycle 10 -> IDLE next cycle, busy=0, done=0. Then DIVU 100/7 -> result=14.
- Separately, drive resetn low mid-MUL -> busy, done and result are 0 immediately.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared types, iteration counts and op-decode helpers for the
//               iterative RV64M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    // Iteration counts: full-width ops and 32-bit word ops
    localparam int MULDIV_ITER_D = 64;
    localparam int MULDIV_ITER_W = 32;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_MULW   = 4'd4,
        MD_DIV    = 4'd5,
        MD_DIVU   = 4'd6,
        MD_REM    = 4'd7,
        MD_REMU   = 4'd8,
        MD_DIVW   = 4'd9,
        MD_DIVUW  = 4'd10,
        MD_REMW   = 4'd11,
        MD_REMUW  = 4'd12
    } muldiv_op_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU,
                          MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
    endfunction

    function automatic logic op_is_word(input muldiv_op_t op);
        return op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    endfunction

    // Word ops whose 32-bit operands are sign-extended on latch
    function automatic logic op_sext_word(input muldiv_op_t op);
        return op inside {MD_MULW, MD_DIVW, MD_REMW};
    endfunction

    // Operand a is treated as a signed quantity (magnitude + sign)
    function automatic logic op_signed_a(input muldiv_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM, MD_DIVW, MD_REMW};
    endfunction

    // Operand b is treated as a signed quantity (magnitude + sign)
    function automatic logic op_signed_b(input muldiv_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM, MD_DIVW, MD_REMW};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_div_iter
// Description : Restoring divider on unsigned magnitudes, one quotient bit per
//               enabled cycle. The quotient register doubles as the dividend
//               shift register.
// Ports       : clk, resetn     - clock, async active-low reset
//               load            - capture dividend/divisor, clear remainder
//               step            - perform one restoring step
//               dividend/divisor- unsigned operands (XLEN)
//               quotient/remainder - current quotient / partial remainder
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit_div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN:0]   w_shifted;
    logic [XLEN:0]   w_trial;

    // The shifted partial remainder is below 2*divisor, so XLEN+1 bits hold
    // it and the top bit of the trial difference is a clean borrow flag.
    assign w_shifted = {r_rem, r_quo[XLEN-1]};
    assign w_trial   = w_shifted - {1'b0, r_div};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_div <= divisor;
        end else if (step) begin
            if (!w_trial[XLEN]) begin
                r_rem <= w_trial[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= w_shifted[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV64M multiply/divide unit for the execute stage.
//               Shift-add multiplier, restoring divider, fast path for divide
//               by zero and signed overflow.
// Ports       : clk, resetn   - clock, async active-low reset
//               valid_in, op  - start request and operation
//               srca, srcb    - operands (rs1, rs2)
//               flush         - abort in-flight operation
//               ack           - consumer takes the result
//               busy, done    - iterating / result valid
//               result        - final result, stable while done is high
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid_in,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    input  logic            ack,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int c_half  = XLEN / 2;
    localparam int c_cnt_w = $clog2(XLEN) + 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    function automatic logic [XLEN-1:0] sext_half(input logic [c_half-1:0] v);
        return {{c_half{v[c_half-1]}}, v};
    endfunction

    logic [1:0]          r_state;
    muldiv_op_t          r_op;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_prod;
    logic [XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]     r_a;
    logic                r_sa;
    logic                r_sb;
    logic                r_fast_dz;
    logic                r_fast_ovf;
    logic [XLEN-1:0]     r_result;

    logic                w_word;
    logic [XLEN-1:0]     w_a_ext;
    logic [XLEN-1:0]     w_b_ext;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN-1:0]     w_min;
    logic                w_dz;
    logic                w_ovf;
    logic                w_fast;
    logic                w_accept;
    logic                w_div_load;
    logic                w_div_step;
    logic [XLEN-1:0]     w_div_dividend;
    logic [XLEN-1:0]     w_q_mag;
    logic [XLEN-1:0]     w_r_mag;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_mul_res;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_div_val;
    logic [XLEN-1:0]     w_div_res;

    // ---------------- operand conditioning at accept ----------------
    assign w_word  = op_is_word(op);
    assign w_a_ext = !w_word ? srca :
                     op_sext_word(op) ? sext_half(srca[c_half-1:0])
                                      : {{c_half{1'b0}}, srca[c_half-1:0]};
    assign w_b_ext = !w_word ? srcb :
                     op_sext_word(op) ? sext_half(srcb[c_half-1:0])
                                      : {{c_half{1'b0}}, srcb[c_half-1:0]};
    assign w_sa    = op_signed_a(op) & w_a_ext[XLEN-1];
    assign w_sb    = op_signed_b(op) & w_b_ext[XLEN-1];
    assign w_mag_a = w_sa ? -w_a_ext : w_a_ext;
    assign w_mag_b = w_sb ? -w_b_ext : w_b_ext;

    // Most negative value of the operating width, as seen after extension
    assign w_min  = w_word ? {{(c_half+1){1'b1}}, {(c_half-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
    assign w_dz   = (w_b_ext == '0);
    assign w_ovf  = op_signed_b(op) && (w_a_ext == w_min) && (w_b_ext == '1);
    assign w_fast = op_is_div(op) && (w_dz || w_ovf);

    assign w_accept = !flush && valid_in &&
                      ((r_state == c_st_idle) || ((r_state == c_st_done) && ack));

    // ---------------- divider ----------------
    // Word ops iterate only 32 times, so the 32-bit magnitude is pre-shifted
    // into the top half where the divider consumes dividend bits first.
    assign w_div_dividend = w_word ? {w_mag_a[c_half-1:0], {c_half{1'b0}}} : w_mag_a;
    assign w_div_load     = w_accept && op_is_div(op);
    assign w_div_step     = (r_state == c_st_div) && (r_cnt != '0);

    muldiv_unit_div_iter #(.XLEN(XLEN)) u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .load      (w_div_load),
        .step      (w_div_step),
        .dividend  (w_div_dividend),
        .divisor   (w_mag_b),
        .quotient  (w_q_mag),
        .remainder (w_r_mag)
    );

    // ---------------- multiplier ----------------
    assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                        (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_fix = (r_sa ^ r_sb) ? -r_prod : r_prod;

    always_comb begin
        w_mul_res = w_prod_fix[2*XLEN-1:XLEN];
        case (r_op)
            MD_MUL:  w_mul_res = w_prod_fix[XLEN-1:0];
            // After only 32 shifts the product sits 32 bits higher
            MD_MULW: w_mul_res = sext_half(r_prod[XLEN-1:c_half]);
            default: w_mul_res = w_prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------- divide result and sign fix-up ----------------
    always_comb begin
        w_quo = (r_sa ^ r_sb) ? -w_q_mag : w_q_mag;
        w_rem = r_sa ? -w_r_mag : w_r_mag;
        if (r_fast_dz) begin
            w_quo = '1;
            w_rem = r_a;
        end else if (r_fast_ovf) begin
            w_quo = r_a;
            w_rem = '0;
        end
        w_div_val = op_is_rem(r_op) ? w_rem : w_quo;
        w_div_res = op_is_word(r_op) ? sext_half(w_div_val[c_half-1:0]) : w_div_val;
    end

    // ---------------- control ----------------
    // The counter counts iteration steps; the cycle after it reaches zero
    // applies the sign fix-up and registers the result. Fast-path ops load
    // a zero count and finalize on the very next edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_st_idle;
            r_op       <= MD_MUL;
            r_cnt      <= '0;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_a        <= '0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_fast_dz  <= 1'b0;
            r_fast_ovf <= 1'b0;
            r_result   <= '0;
        end else if (flush) begin
            r_state <= c_st_idle;
        end else if (w_accept) begin
            r_op       <= op;
            r_a        <= w_a_ext;
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_fast_dz  <= op_is_div(op) && w_dz;
            r_fast_ovf <= op_is_div(op) && w_ovf && !w_dz;
            r_mcand    <= w_mag_a;
            r_prod     <= {{XLEN{1'b0}}, w_mag_b};
            r_cnt      <= w_fast ? '0 :
                          w_word ? c_cnt_w'(MULDIV_ITER_W) : c_cnt_w'(MULDIV_ITER_D);
            r_state    <= op_is_div(op) ? c_st_div : c_st_mul;
        end else begin
            case (r_state)
                c_st_mul: begin
                    if (r_cnt != '0) begin
                        r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
                        r_cnt  <= r_cnt - c_cnt_one;
                    end else begin
                        r_result <= w_mul_res;
                        r_state  <= c_st_done;
                    end
                end
                c_st_div: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        r_result <= w_div_res;
                        r_state  <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (ack) begin
                        r_state <= c_st_idle;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == c_st_mul) || (r_state == c_st_div);
    assign done   = (r_state == c_st_done);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b1;
    logic        valid_in = 1'b0;
    logic        flush    = 1'b0;
    logic        ack      = 1'b0;
    muldiv_op_t  op       = MD_MUL;
    logic [63:0] srca     = '0;
    logic [63:0] srcb     = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .valid_in (valid_in),
        .op       (op),
        .srca     (srca),
        .srcb     (srcb),
        .flush    (flush),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Present one request for one edge, then scramble operands to show they
    // were latched. Returns at the falling edge right after the accept edge.
    task automatic start_op(input muldiv_op_t o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        valid_in = 1'b1;
        op       = o;
        srca     = a;
        srcb     = b;
        @(negedge clk);
        valid_in = 1'b0;
        srca     = ~a;
        srcb     = ~b;
    endtask

    // Number of edges from accept until done is first seen (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_op();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #10;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 64'h0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_mul();
        int lat;
        start_op(MD_MUL, 64'd7, -64'sd3);
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL mul_busy_after_accept: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        wait_done(lat);
        n_checks++; if (lat != 65) begin n_errors++; $display("FAIL mul_latency: got %0d expected 65", lat); end
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_errors++; $display("FAIL mul_result: got %h expected ffffffffffffffeb", result); end
        repeat (3) @(negedge clk);
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_errors++; $display("FAIL mul_hold_result: got %h expected ffffffffffffffeb", result); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_errors++; $display("FAIL mul_hold_flags: got busy=%b done=%b expected busy=0 done=1", busy, done); end
        release_op();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL mul_after_ack: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_mulh();
        int lat;
        start_op(MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_done(lat);
        n_checks++; if (result !== 64'd1) begin n_errors++; $display("FAIL mulhu_result: got %h expected 1", result); end
        release_op();
        start_op(MD_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_done(lat);
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL mulh_result: got %h expected ffffffffffffffff", result); end
        release_op();
        start_op(MD_MULW, 64'h1234_5678_4000_0000, 64'hABCD_0000_0000_0003);
        wait_done(lat);
        n_checks++; if (lat != 33) begin n_errors++; $display("FAIL mulw_latency: got %0d expected 33", lat); end
        n_checks++; if (result !== 64'hFFFF_FFFF_C000_0000) begin n_errors++; $display("FAIL mulw_result: got %h expected ffffffffc0000000", result); end
        release_op();
    endtask

    task automatic test_div_fast();
        int lat;
        start_op(MD_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        wait_done(lat);
        n_checks++; if (lat != 1) begin n_errors++; $display("FAIL divw_ovf_latency: got %0d expected 1", lat); end
        n_checks++; if (result !== 64'hFFFF_FFFF_8000_0000) begin n_errors++; $display("FAIL divw_ovf_result: got %h expected ffffffff80000000", result); end
        release_op();
        start_op(MD_REMW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        wait_done(lat);
        n_checks++; if (result !== 64'h0) begin n_errors++; $display("FAIL remw_ovf_result: got %h expected 0", result); end
        release_op();
        start_op(MD_DIV, -64'sd20, 64'd0);
        wait_done(lat);
        n_checks++; if (lat != 1) begin n_errors++; $display("FAIL div_zero_latency: got %0d expected 1", lat); end
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL div_zero_result: got %h expected ffffffffffffffff", result); end
        release_op();
        start_op(MD_REMU, 64'd20, 64'd0);
        wait_done(lat);
        n_checks++; if (result !== 64'd20) begin n_errors++; $display("FAIL remu_zero_result: got %h expected 14", result); end
        release_op();
    endtask

    task automatic test_div_signed();
        int lat;
        start_op(MD_DIV, -64'sd20, 64'd3);
        wait_done(lat);
        n_checks++; if (lat != 65) begin n_errors++; $display("FAIL div_latency: got %0d expected 65", lat); end
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_errors++; $display("FAIL div_signed_result: got %h expected fffffffffffffffa", result); end
        release_op();
        start_op(MD_REM, 64'd20, -64'sd3);
        wait_done(lat);
        n_checks++; if (result !== 64'd2) begin n_errors++; $display("FAIL rem_signed_result: got %h expected 2", result); end
        release_op();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(MD_REM, -64'sd7, 64'd2);
        wait_done(lat);
        n_checks++; if (lat != 65) begin n_errors++; $display("FAIL rem_latency: got %0d expected 65", lat); end
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL rem_result: got %h expected ffffffffffffffff", result); end
        ack      = 1'b1;
        valid_in = 1'b1;
        op       = MD_DIVUW;
        srca     = 64'h0000_0000_FFFF_FFFF;
        srcb     = 64'd2;
        @(negedge clk);
        ack      = 1'b0;
        valid_in = 1'b0;
        srca     = '0;
        srcb     = '0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        wait_done(lat);
        n_checks++; if (lat != 33) begin n_errors++; $display("FAIL divuw_latency: got %0d expected 33", lat); end
        n_checks++; if (result !== 64'h0000_0000_7FFF_FFFF) begin n_errors++; $display("FAIL divuw_result: got %h expected 000000007fffffff", result); end
        release_op();
    endtask

    task automatic test_flush();
        int lat;
        start_op(MD_DIV, 64'd1000, 64'd3);
        repeat (9) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL flush_pre_busy: got %b expected 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL flush_idle: got busy=%b done=%b expected 0 0", busy, done); end
        // flush wins over a simultaneous start in IDLE
        flush    = 1'b1;
        valid_in = 1'b1;
        op       = MD_DIVU;
        srca     = 64'd5;
        srcb     = 64'd1;
        @(negedge clk);
        flush    = 1'b0;
        valid_in = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL flush_blocks_start: got busy=%b done=%b expected 0 0", busy, done); end
        start_op(MD_DIVU, 64'd100, 64'd7);
        wait_done(lat);
        n_checks++; if (lat != 65) begin n_errors++; $display("FAIL divu_latency: got %0d expected 65", lat); end
        n_checks++; if (result !== 64'd14) begin n_errors++; $display("FAIL divu_result: got %h expected e", result); end
        release_op();
    endtask

    task automatic test_async_reset();
        start_op(MD_MUL, 64'd5, 64'd6);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL async_reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 64'h0) begin n_errors++; $display("FAIL async_reset_result: got %h expected 0", result); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div_fast();
        test_div_signed();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
